// File: rtl/tdc_sequencer.sv
// TDC measurement sequencer: runs 2^AVG_LOG2 pulse-counter conversions per request,
// times each one in clk cycles and returns the truncated average (or a timeout flag).
module tdc_sequencer #(
  parameter int TIME_BITS      = 16,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 abort,
  input  logic                 pulse_counter_full,
  output logic                 cnt_clear,
  output logic                 cnt_en,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TIME_BITS-1:0] res_data,
  output logic                 res_timeout
);

  localparam int SUM_BITS = TIME_BITS + AVG_LOG2;
  localparam logic [TIME_BITS-1:0] TIME_LAST = TIME_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [AVG_LOG2-1:0]  IDX_LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_reg;
  logic [TIME_BITS-1:0]  time_cnt_reg;
  logic [SUM_BITS-1:0]   sum_reg;
  logic [AVG_LOG2-1:0]   meas_idx_reg;
  logic [TIME_BITS-1:0]  res_data_reg;
  logic                  res_timeout_reg;
  logic [SUM_BITS-1:0]   sum_next;

  // Sum including the conversion being accumulated; its upper bits are the average.
  assign sum_next = sum_reg + SUM_BITS'(time_cnt_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      time_cnt_reg    <= '0;
      sum_reg         <= '0;
      meas_idx_reg    <= '0;
      res_data_reg    <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            sum_reg         <= '0;
            meas_idx_reg    <= '0;
            res_timeout_reg <= 1'b0;
            state_reg       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else begin
            time_cnt_reg <= '0;
            state_reg    <= S_RUN;
          end
        end
        S_RUN: begin
          // End-of-conversion beats a coincident timeout.
          if (abort) begin
            state_reg <= S_IDLE;
          end else if (pulse_counter_full) begin
            state_reg <= S_ACCUM;
          end else if (time_cnt_reg == TIME_LAST) begin
            res_timeout_reg <= 1'b1;
            res_data_reg    <= '1;
            state_reg       <= S_DONE;
          end else begin
            time_cnt_reg <= time_cnt_reg + TIME_BITS'(1);
          end
        end
        S_ACCUM: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else begin
            sum_reg <= sum_next;
            if (meas_idx_reg == IDX_LAST) begin
              res_data_reg <= sum_next[SUM_BITS-1:AVG_LOG2];
              state_reg    <= S_DONE;
            end else begin
              meas_idx_reg <= meas_idx_reg + AVG_LOG2'(1);
              state_reg    <= S_CLEAR;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign cnt_clear   = (state_reg == S_CLEAR);
  assign cnt_en      = (state_reg == S_RUN);
  assign res_valid   = (state_reg == S_DONE);
  assign res_data    = res_data_reg;
  assign res_timeout = res_timeout_reg;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed bench for tdc_sequencer: table of per-conversion times with hand-computed
// averages/latencies, plus reset, backpressure and abort sequences.
module tb_tdc_sequencer;

  localparam int TB = 8;
  localparam int NEVER = 9999;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          abort = 1'b0;
  logic          pulse_counter_full = 1'b0;
  logic          cnt_clear;
  logic          cnt_en;
  logic          busy;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [TB-1:0] res_data;
  logic          res_timeout;

  int n_pass = 0;
  int n_total = 0;

  tdc_sequencer #(.TIME_BITS(TB), .AVG_LOG2(2), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .abort(abort), .pulse_counter_full(pulse_counter_full),
    .cnt_clear(cnt_clear), .cnt_en(cnt_en), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t0, t1, t2, t3;
    int exp_data;
    int exp_to;
    int exp_clears;
    int exp_en;
    int exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays the pulse counter: full is raised on RUN cycle t+1
  // of each conversion. Optionally aborts on the 2nd RUN cycle of conversion abort_conv.
  task automatic run_burst(input int t0, input int t1, input int t2, input int t3,
                           input int abort_conv, output bit got_valid,
                           output int clears, output int en, output int lat);
    int t[4];
    int run_k;
    int conv;
    bit aborted;
    t = '{t0, t1, t2, t3};
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1; clears = 0; en = 0; conv = 0; run_k = 0; aborted = 0; got_valid = 0;
    while (lat < 2000) begin
      if (res_valid) begin
        got_valid = 1;
        break;
      end
      if (aborted) break;
      if (cnt_clear) begin
        clears++;
        conv++;
        run_k = 0;
      end
      if (cnt_en) begin
        run_k++;
        en++;
      end
      pulse_counter_full = cnt_en && conv >= 1 && conv <= 4 && (run_k == t[conv-1] + 1);
      if (abort_conv == conv && cnt_en && run_k == 2) begin
        abort = 1'b1;
        aborted = 1;
      end
      tick();
      abort = 1'b0;
      lat++;
    end
    pulse_counter_full = 1'b0;
  endtask

  initial begin
    bit gv;
    int clears, en, lat;
    logic [TB-1:0] held;

    // times -> avg, timeout, clears, cnt_en cycles, accept-to-valid latency
    vecs[0] = '{10, 10, 10, 10, 10, 0, 4, 44, 53};
    vecs[1] = '{10, 11, 12, 13, 11, 0, 4, 50, 59};
    vecs[2] = '{0, 0, 0, 3, 0, 0, 4, 7, 16};
    vecs[3] = '{NEVER, 0, 0, 0, 255, 1, 1, 200, 202};
    vecs[4] = '{199, 0, 0, 0, 49, 0, 4, 203, 212};
    vecs[5] = '{20, 30, 40, 50, 35, 0, 4, 144, 153};
    vecs[6] = '{199, 199, 199, 199, 199, 0, 4, 800, 809};

    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_clear", cnt_clear, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_timeout", res_timeout, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_burst(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3, 0, gv, clears, en, lat);
      $display("vec %0d: data=%0d to=%0d clears=%0d en=%0d lat=%0d", i, res_data, res_timeout, clears, en, lat);
      chk($sformatf("v%0d_valid", i), gv, 1);
      chk($sformatf("v%0d_data", i), res_data, vecs[i].exp_data);
      chk($sformatf("v%0d_timeout", i), res_timeout, vecs[i].exp_to);
      chk($sformatf("v%0d_clears", i), clears, vecs[i].exp_clears);
      chk($sformatf("v%0d_en", i), en, vecs[i].exp_en);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy", i), busy, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk($sformatf("v%0d_idle_ready", i), req_ready, 1);
      chk($sformatf("v%0d_idle_valid", i), res_valid, 0);
    end

    // Backpressure in DONE while poking req_valid and abort.
    run_burst(10, 11, 12, 13, 0, gv, clears, en, lat);
    chk("bp_valid", gv, 1);
    held = res_data;
    chk("bp_data", held, 11);
    for (int k = 0; k < 5; k++) begin
      req_valid = k[0];
      abort = ~k[0];
      tick();
      $display("bp cycle %0d: valid=%0d data=%0d req_ready=%0d", k, res_valid, res_data, req_ready);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_data", res_data, 11);
      chk("bp_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("bp release: req_ready=%0d busy=%0d", req_ready, busy);
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_busy", busy, 0);

    // Abort in the 3rd conversion, then an immediate fresh burst.
    run_burst(5, 5, 5, 5, 3, gv, clears, en, lat);
    $display("abort: clears=%0d en=%0d busy=%0d cnt_en=%0d", clears, en, busy, cnt_en);
    chk("ab_no_result", gv, 0);
    chk("ab_clears", clears, 3);
    chk("ab_cnt_en", cnt_en, 0);
    chk("ab_busy", busy, 0);
    chk("ab_res_valid", res_valid, 0);
    chk("ab_req_ready", req_ready, 1);
    run_burst(4, 4, 4, 8, 0, gv, clears, en, lat);
    $display("post-abort: data=%0d clears=%0d lat=%0d", res_data, clears, lat);
    chk("pa_valid", gv, 1);
    chk("pa_data", res_data, 5);
    chk("pa_clears", clears, 4);
    chk("pa_lat", lat, 33);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Async reset in the middle of RUN.
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mr_running", cnt_en, 1);
    rst = 1'b0;
    #1;
    $display("mid-run reset: cnt_en=%0d busy=%0d req_ready=%0d", cnt_en, busy, req_ready);
    chk("mr_cnt_en", cnt_en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_res_valid", res_valid, 0);
    chk("mr_req_ready", req_ready, 1);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mr_no_clear", cnt_clear, 0);
      chk("mr_stay_idle", busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdc_sequencer.md
Name: tdc_sequencer

Overview:
- Measurement sequencer for the time-to-digital converter.
- Accepts a measurement request over a valid/ready handshake and runs 2^AVG_LOG2 back-to-back conversions on the shared pulse-counter datapath.
- For each conversion it issues a one-cycle clear, enables the counter, and times the run in clk cycles until pulse_counter_full.
- Returns the averaged time over a valid/ready result handshake, and aborts the burst with a flagged result on timeout.

Parameters:
TIME_BITS, 16, width of per-conversion time counter and of res_data
AVG_LOG2, 2, log2 of conversions per request (1..8); averaging is sum >> AVG_LOG2
TIMEOUT_CYCLES, 1000, max RUN cycles per conversion; must be >= 1 and <= 2^TIME_BITS - 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request a measurement burst
req_ready  out  1  sequencer idle, request accepted when req_valid && req_ready
abort  in  1  synchronous abort of current burst
pulse_counter_full  in  1  pulse counter reached its max (end of conversion)
cnt_clear  out  1  one-cycle clear to pulse counter
cnt_en  out  1  pulse counter enable
busy  out  1  high in every state except IDLE
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid && res_ready
res_data  out  TIME_BITS  averaged conversion time in clk cycles
res_timeout  out  1  result is a timeout abort

Behaviour:
- Reset (rst=0, async): state=IDLE; time_cnt, sum, meas_idx, res_data, res_timeout cleared. Outputs: req_ready=1, all other outputs 0.
- States: IDLE, CLEAR, RUN, ACCUM, DONE. All outputs are decoded from registered state/registers only (no input-to-output combinational path).
- IDLE:
  - req_ready=1.
  - On req_valid: sum<=0, meas_idx<=0, res_timeout<=0, go to CLEAR.
  - abort is ignored in IDLE.
- CLEAR:
  - cnt_clear=1 for exactly one cycle; time_cnt<=0; go to RUN.
- RUN:
  - cnt_en=1.
  - If pulse_counter_full: go to ACCUM; time_cnt is held, not incremented.
  - Else if time_cnt == TIMEOUT_CYCLES-1: res_timeout<=1, res_data<=all ones, go to DONE. The partial sum is discarded.
  - Else: time_cnt<=time_cnt+1.
  - Full and timeout in the same cycle: full wins.
  - Recorded time = number of RUN cycles before the cycle in which full was seen (full in the first RUN cycle gives 0).
- ACCUM:
  - sum<=sum+time_cnt. sum is TIME_BITS+AVG_LOG2 wide and cannot overflow.
  - If meas_idx == 2^AVG_LOG2-1: res_data<=(sum+time_cnt)>>AVG_LOG2 (truncating), go to DONE.
  - Else: meas_idx<=meas_idx+1, go to CLEAR.
- DONE:
  - res_valid=1; res_data and res_timeout held stable.
  - On res_ready: go to IDLE. The earliest new request is accepted the following cycle.
  - req_valid is ignored while not in IDLE (req_ready=0).
- abort:
  - In CLEAR, RUN or ACCUM: go to IDLE next cycle; no result is produced; cnt_en drops next cycle.
  - In DONE, abort is ignored; the result must be consumed.
- Latency per conversion = 1 (CLEAR) + (t+1) (RUN) + 1 (ACCUM) cycles, where t is the recorded time.
- Reset mid-operation: immediate return to the reset values above; a pending result is lost.
- Unknown or illegal state: go to IDLE.

Test Plan:
All scenarios use TIME_BITS=8, AVG_LOG2=2, TIMEOUT_CYCLES=200.
1. Reset: assert rst=0 mid-RUN -> same cycle cnt_en=0, busy=0, res_valid=0, req_ready=1; after release the sequencer stays in IDLE with no spurious cnt_clear.
2. Constant time: request; per conversion, assert full after 10 RUN cycles (full seen in 11th RUN cycle) -> exactly 4 cnt_clear pulses, each followed by 11 cnt_en cycles; res_data=10, res_timeout=0; total latency from accept to res_valid = 4*(1+11+1)+1 = 53 cycles.
3. Averaging/truncation: times 10, 11, 12, 13 -> sum 46, res_data=11; times 0,0,0,3 -> res_data=0.
4. Timeout: full never asserted -> after 200 RUN cycles of the first conversion, res_valid=1, res_data=8'hFF, res_timeout=1, with no further cnt_clear. Full asserted on RUN cycle 200 (time_cnt=199) -> counted as 199, no timeout.
5. Backpressure: hold res_ready=0 for 5 cycles in DONE while pulsing req_valid and abort -> res_data stable, req_ready=0, abort ignored; res_ready=1 -> IDLE next cycle, req_ready=1.
6. Abort: assert abort in 3rd conversion RUN -> IDLE next cycle, cnt_en=0, no res_valid; an immediate new request then runs 4 fresh conversions with sum restarted from 0.
